// File: rtl/number_spawner_pkg.sv
// Shared types and helpers for the falling-number spawner: FSM states, LFSR step, digit folding.
package number_spawner_pkg;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    WAIT_SPAWN = 3'd1,
    LOAD       = 3'd2,
    LAUNCH     = 3'd3,
    ACTIVE     = 3'd4,
    RETIRE     = 3'd5
  } state_t;

  localparam int          FIXED_POINT_MULTIPLIER = 64;
  localparam logic [15:0] LFSR_MASK              = 16'hB400;
  localparam int          CNT_W                  = 16;

  // Galois form: the bit shifted out feeds back through the mask.
  function automatic logic [15:0] lfsr_next(input logic [15:0] q);
    logic [15:0] shifted;
    shifted = {1'b0, q[15:1]};
    return q[0] ? (shifted ^ LFSR_MASK) : shifted;
  endfunction

  function automatic logic [3:0] digit_of(input logic [3:0] v);
    return (v >= 4'd10) ? (v - 4'd10) : v;
  endfunction

endpackage

// File: rtl/number_spawner_lfsr.sv
// 16-bit Galois LFSR; free-running whenever reset is released.
module lfsr16
  import number_spawner_pkg::*;
(
  input  logic        clk,
  input  logic        resetN,
  input  logic [15:0] seed,
  output logic [15:0] q
);

  // An all-zero seed would lock the register, so it is replaced by 1.
  always_ff @(posedge clk) begin
    if (!resetN) begin
      q <= (seed == 16'h0000) ? 16'h0001 : seed;
    end else begin
      q <= lfsr_next(q);
    end
  end

endmodule

// File: rtl/number_spawner.sv
// Spawn controller for one falling-number mover: random launch parameters, re-init pulse,
// lifetime tracking and a saturating collection counter.
module number_spawner
  import number_spawner_pkg::*;
#(
  parameter int          SPAWN_PERIOD_FRAMES = 90,
  parameter int          LIFETIME_FRAMES     = 150,
  parameter int          X_MIN               = 32,
  parameter int          X_MAX               = 600,
  parameter int          START_Y             = 0,
  parameter int          SPEED_MIN           = 16,
  parameter int          SPEED_MAX           = 64,
  parameter logic [15:0] LFSR_SEED           = 16'hACE1
) (
  input  logic               clk,
  input  logic               resetN,
  input  logic               startOfFrame,
  input  logic               enable,
  input  logic               collected,
  output logic signed [31:0] X_SPEED,
  output logic        [31:0] INITIAL_X,
  output logic        [31:0] INITIAL_Y,
  output logic               moverResetN,
  output logic               active,
  output logic        [3:0]  digit,
  output logic        [7:0]  hitCount
);

  localparam logic [9:0]       SPAN        = 10'(X_MAX - X_MIN);
  localparam logic [10:0]      SPAN_P1     = 11'(X_MAX - X_MIN + 1);
  localparam logic [CNT_W-1:0] PERIOD_LAST = CNT_W'(SPAWN_PERIOD_FRAMES - 1);
  localparam logic [CNT_W-1:0] LIFE_LAST   = CNT_W'(LIFETIME_FRAMES - 1);

  state_t state, state_next;
  logic [15:0]      lfsr_q;
  logic [CNT_W-1:0] frame_cnt, frame_next;
  logic [CNT_W-1:0] life_cnt, life_next;
  logic [9:0]       cand, cand_next;
  logic [10:0]      cand_sub;
  logic             snap_sign, snap_sign_next;
  logic [3:0]       snap_speed, snap_speed_next;
  logic [3:0]       snap_digit, snap_digit_next;
  logic [31:0]      mag_sum, mag;
  logic [31:0]      xs_next, ix_next;
  logic [3:0]       dig_next;
  logic [7:0]       hit_next;

  lfsr16 u_lfsr (
    .clk    (clk),
    .resetN (resetN),
    .seed   (LFSR_SEED),
    .q      (lfsr_q)
  );

  assign cand_sub = {1'b0, cand} - SPAN_P1;
  assign mag_sum  = 32'(SPEED_MIN) + {28'd0, snap_speed};
  assign mag      = (mag_sum > 32'(SPEED_MAX)) ? 32'(SPEED_MAX) : mag_sum;

  // Next-state and next-value logic for the FSM, counters and launch outputs.
  always_comb begin
    state_next      = state;
    frame_next      = frame_cnt;
    life_next       = life_cnt;
    cand_next       = cand;
    snap_sign_next  = snap_sign;
    snap_speed_next = snap_speed;
    snap_digit_next = snap_digit;
    xs_next         = X_SPEED;
    ix_next         = INITIAL_X;
    dig_next        = digit;
    hit_next        = hitCount;
    case (state)
      IDLE: begin
        if (enable) begin
          state_next = WAIT_SPAWN;
          frame_next = '0;
        end else begin
          state_next = IDLE;
        end
      end
      WAIT_SPAWN: begin
        if (!enable) begin
          state_next = IDLE;
        end else if (startOfFrame) begin
          if (frame_cnt == PERIOD_LAST) begin
            state_next      = LOAD;
            frame_next      = '0;
            cand_next       = lfsr_q[9:0];
            snap_sign_next  = lfsr_q[15];
            snap_speed_next = lfsr_q[13:10];
            snap_digit_next = lfsr_q[3:0];
          end else begin
            frame_next = frame_cnt + CNT_W'(1);
          end
        end else begin
          state_next = WAIT_SPAWN;
        end
      end
      // Repeated subtraction folds the 10-bit candidate into 0..span without a divider.
      LOAD: begin
        if (cand > SPAN) begin
          cand_next = cand_sub[9:0];
        end else begin
          state_next = LAUNCH;
          ix_next    = 32'(X_MIN) + {22'd0, cand};
          xs_next    = snap_sign ? (32'd0 - mag) : mag;
          dig_next   = digit_of(snap_digit);
        end
      end
      LAUNCH: begin
        state_next = ACTIVE;
        life_next  = '0;
      end
      ACTIVE: begin
        if (collected) begin
          state_next = RETIRE;
          hit_next   = (hitCount == 8'hFF) ? hitCount : (hitCount + 8'd1);
        end else if (startOfFrame) begin
          if (life_cnt == LIFE_LAST) begin
            state_next = RETIRE;
          end else begin
            life_next = life_cnt + CNT_W'(1);
          end
        end else begin
          state_next = ACTIVE;
        end
      end
      RETIRE: begin
        if (enable) begin
          state_next = WAIT_SPAWN;
          frame_next = '0;
        end else begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State, datapath and output registers; outputs follow the state being entered.
  always_ff @(posedge clk) begin
    if (!resetN) begin
      state       <= IDLE;
      frame_cnt   <= '0;
      life_cnt    <= '0;
      cand        <= 10'd0;
      snap_sign   <= 1'b0;
      snap_speed  <= 4'd0;
      snap_digit  <= 4'd0;
      X_SPEED     <= 32'sd0;
      INITIAL_X   <= 32'(X_MIN);
      INITIAL_Y   <= 32'(START_Y);
      moverResetN <= 1'b0;
      active      <= 1'b0;
      digit       <= 4'd0;
      hitCount    <= 8'd0;
    end else begin
      state       <= state_next;
      frame_cnt   <= frame_next;
      life_cnt    <= life_next;
      cand        <= cand_next;
      snap_sign   <= snap_sign_next;
      snap_speed  <= snap_speed_next;
      snap_digit  <= snap_digit_next;
      X_SPEED     <= xs_next;
      INITIAL_X   <= ix_next;
      INITIAL_Y   <= 32'(START_Y);
      moverResetN <= (state_next != LAUNCH);
      active      <= (state_next == ACTIVE);
      digit       <= dig_next;
      hitCount    <= hit_next;
    end
  end

endmodule

// File: tb/tb_number_spawner.sv
// Self-checking bench for number_spawner: a frame-level reference model plus directed scenarios.
module tb_number_spawner;

  localparam int          PERIOD = 3;
  localparam int          LIFE   = 4;
  localparam int          XMIN   = 32;
  localparam int          XMAX   = 600;
  localparam logic [15:0] SEED   = 16'hACE1;

  localparam int P_IDLE = 0, P_WAIT = 1, P_LOAD = 2, P_LAUNCH = 3, P_ACTIVE = 4, P_RETIRE = 5;

  logic clk = 1'b0;
  logic resetN = 1'b0, startOfFrame = 1'b0, enable = 1'b0, collected = 1'b0;

  logic signed [31:0] X_SPEED, xs2;
  logic [31:0] INITIAL_X, INITIAL_Y, ix2, iy2;
  logic        moverResetN, active, mrn2, act2;
  logic [3:0]  digit, dig2;
  logic [7:0]  hitCount, hit2;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  number_spawner #(
    .SPAWN_PERIOD_FRAMES(PERIOD), .LIFETIME_FRAMES(LIFE), .X_MIN(XMIN), .X_MAX(XMAX),
    .START_Y(0), .SPEED_MIN(16), .SPEED_MAX(64), .LFSR_SEED(SEED)
  ) dut (
    .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame), .enable(enable),
    .collected(collected), .X_SPEED(X_SPEED), .INITIAL_X(INITIAL_X), .INITIAL_Y(INITIAL_Y),
    .moverResetN(moverResetN), .active(active), .digit(digit), .hitCount(hitCount)
  );

  number_spawner #(
    .SPAWN_PERIOD_FRAMES(PERIOD), .LIFETIME_FRAMES(LIFE), .X_MIN(0), .X_MAX(9),
    .START_Y(0), .SPEED_MIN(16), .SPEED_MAX(64), .LFSR_SEED(16'h1234)
  ) dut_narrow (
    .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame), .enable(enable),
    .collected(collected), .X_SPEED(xs2), .INITIAL_X(ix2), .INITIAL_Y(iy2),
    .moverResetN(mrn2), .active(act2), .digit(dig2), .hitCount(hit2)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference arithmetic taken straight from the launch rules.
  function automatic logic [15:0] lfsr_step(input logic [15:0] q);
    return q[0] ? ((q >> 1) ^ 16'hB400) : (q >> 1);
  endfunction

  function automatic logic [31:0] launch_x(input logic [15:0] s, input int xmin, input int xmax);
    return 32'(xmin + (int'(s[9:0]) % (xmax - xmin + 1)));
  endfunction

  function automatic int load_extra(input logic [15:0] s, input int xmin, input int xmax);
    return int'(s[9:0]) / (xmax - xmin + 1);
  endfunction

  function automatic logic [31:0] launch_speed(input logic [15:0] s);
    int m;
    m = 16 + int'(s[13:10]);
    if (m > 64) m = 64;
    return s[15] ? 32'(-m) : 32'(m);
  endfunction

  function automatic logic [31:0] launch_digit(input logic [15:0] s);
    return 32'(int'(s[3:0]) % 10);
  endfunction

  // Behavioural model
  logic        m_valid = 1'b0;
  logic [15:0] m_lfsr = 16'h0000;
  int          m_phase = P_IDLE, m_frames = 0, m_life = 0, m_load_left = 0;
  logic [15:0] m_snap = 16'h0000;
  logic [31:0] exp_xs = 32'd0, exp_ix = 32'd0, exp_dig = 32'd0, exp_hit = 32'd0;
  logic        exp_act = 1'b0, exp_mrn = 1'b0;

  always @(posedge clk) begin
    if (!resetN) begin
      m_valid <= 1'b1;
      m_lfsr  <= (SEED == 16'h0000) ? 16'h0001 : SEED;
      m_phase <= P_IDLE;
      m_frames <= 0;
      m_life  <= 0;
      exp_xs  <= 32'd0;
      exp_ix  <= 32'(XMIN);
      exp_dig <= 32'd0;
      exp_hit <= 32'd0;
      exp_act <= 1'b0;
      exp_mrn <= 1'b0;
    end else begin
      m_lfsr  <= lfsr_step(m_lfsr);
      exp_mrn <= 1'b1;
      case (m_phase)
        P_IDLE: if (enable) begin m_phase <= P_WAIT; m_frames <= 0; end
        P_WAIT: begin
          if (!enable) m_phase <= P_IDLE;
          else if (startOfFrame) begin
            if (m_frames + 1 == PERIOD) begin
              m_phase <= P_LOAD;
              m_snap <= m_lfsr;
              m_load_left <= load_extra(m_lfsr, XMIN, XMAX);
            end else m_frames <= m_frames + 1;
          end
        end
        P_LOAD: begin
          if (m_load_left == 0) begin
            m_phase <= P_LAUNCH;
            exp_mrn <= 1'b0;
            exp_ix  <= launch_x(m_snap, XMIN, XMAX);
            exp_xs  <= launch_speed(m_snap);
            exp_dig <= launch_digit(m_snap);
          end else m_load_left <= m_load_left - 1;
        end
        P_LAUNCH: begin m_phase <= P_ACTIVE; exp_act <= 1'b1; m_life <= 0; end
        P_ACTIVE: begin
          if (collected) begin
            m_phase <= P_RETIRE; exp_act <= 1'b0;
            if (exp_hit < 32'd255) exp_hit <= exp_hit + 32'd1;
          end else if (startOfFrame) begin
            if (m_life + 1 == LIFE) begin m_phase <= P_RETIRE; exp_act <= 1'b0; end
            else m_life <= m_life + 1;
          end
        end
        P_RETIRE: begin
          if (enable) begin m_phase <= P_WAIT; m_frames <= 0; end
          else m_phase <= P_IDLE;
        end
        default: m_phase <= P_IDLE;
      endcase
    end
  end

  // Cycle-by-cycle comparison against the model, plus narrow-range instance sanity.
  logic prev_rst = 1'b0, prev_mrn2 = 1'b1;
  always @(negedge clk) begin
    if (m_valid) begin
      check("X_SPEED", X_SPEED, exp_xs);
      check("INITIAL_X", INITIAL_X, exp_ix);
      check("INITIAL_Y", INITIAL_Y, 32'd0);
      check("digit", {28'd0, digit}, exp_dig);
      check("hitCount", {24'd0, hitCount}, exp_hit);
      check("active", {31'd0, active}, {31'd0, exp_act});
      check("moverResetN", {31'd0, moverResetN}, {31'd0, exp_mrn});
      if (act2) begin
        check("narrow_x_range", {31'd0, (ix2 <= 32'd9)}, 32'd1);
        check("narrow_digit", {31'd0, (dig2 <= 4'd9)}, 32'd1);
        check("narrow_y", iy2, 32'd0);
      end
      if (resetN && prev_rst && !mrn2) check("narrow_mrn_pulse", {31'd0, prev_mrn2}, 32'd1);
    end
    prev_rst  <= resetN;
    prev_mrn2 <= mrn2;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic frame();
    startOfFrame = 1'b1;
    tick(1);
    startOfFrame = 1'b0;
    tick(3);
  endtask

  task automatic spawn(output int frames_used);
    frames_used = 0;
    while (!active && frames_used < 8) begin
      frame();
      frames_used++;
    end
    check("spawn_timeout", {31'd0, active}, 32'd1);
  endtask

  task automatic collect();
    collected = 1'b1;
    tick(1);
    collected = 1'b0;
  endtask

  initial begin
    int n;
    int sp;
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int sp;
    // Pin the model with hand-computed launches.
    check("lit_x_83FF", launch_x(16'h83FF, XMIN, XMAX), 32'd486);
    check("lit_speed_83FF", launch_speed(16'h83FF), 32'hFFFF_FFF0);
    check("lit_digit_83FF", launch_digit(16'h83FF), 32'd5);
    check("lit_speed_BFFF", launch_speed(16'hBFFF), 32'hFFFF_FFE1);
    check("lit_load_83FF", 32'(load_extra(16'h83FF, XMIN, XMAX)), 32'd1);
    check("lit_narrow_x", launch_x(16'h83FF, 0, 9), 32'd3);

    tick(3);
    check("rst_active", {31'd0, active}, 32'd0);
    check("rst_mrn", {31'd0, moverResetN}, 32'd0);
    check("rst_x", INITIAL_X, 32'd32);
    check("rst_hit", {24'd0, hitCount}, 32'd0);

    // First launch
    resetN = 1'b1;
    enable = 1'b1;
    tick(2);
    spawn(n);
    check("first_spawn_frames", 32'(n), 32'd3);
    check("x_range", {31'd0, (INITIAL_X >= 32'd32 && INITIAL_X <= 32'd600)}, 32'd1);
    check("digit_range", {31'd0, (digit <= 4'd9)}, 32'd1);
    sp = X_SPEED[31] ? -int'(X_SPEED) : int'(X_SPEED);
    check("speed_range", {31'd0, (sp >= 16 && sp <= 31)}, 32'd1);

    // Expiry without collection, then relaunch
    repeat (4) frame();
    check("expired_active", {31'd0, active}, 32'd0);
    check("expired_hit", {24'd0, hitCount}, 32'd0);
    spawn(n);
    check("respawn_frames", 32'(n), 32'd3);

    // Collection on the final lifetime pulse wins
    repeat (3) frame();
    startOfFrame = 1'b1;
    collected = 1'b1;
    tick(1);
    startOfFrame = 1'b0;
    collected = 1'b0;
    tick(2);
    check("tie_hit", {24'd0, hitCount}, 32'd1);
    collect();
    tick(1);
    check("idle_collect_hit", {24'd0, hitCount}, 32'd1);

    // enable drop while active: object lives out, then idle
    spawn(n);
    enable = 1'b0;
    repeat (4) frame();
    check("disable_retired", {31'd0, active}, 32'd0);
    repeat (4) frame();
    check("disable_idle", {31'd0, active}, 32'd0);

    // Reset while active
    enable = 1'b1;
    tick(2);
    spawn(n);
    resetN = 1'b0;
    tick(1);
    check("midrst_active", {31'd0, active}, 32'd0);
    check("midrst_mrn", {31'd0, moverResetN}, 32'd0);
    check("midrst_hit", {24'd0, hitCount}, 32'd0);

    // Saturation
    resetN = 1'b1;
    tick(1);
    for (int i = 0; i < 300; i++) begin
      spawn(n);
      collect();
    end
    tick(2);
    check("hit_saturated", {24'd0, hitCount}, 32'd255);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
